// File: rtl/seq_pkg.sv
// Shared types and default parameter values for the core sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_RST,
        RUN,
        FINISH
    } seq_state_e;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_RST_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/sat_counter.sv
// Clearable, enable-gated up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/core_sequencer.sv
// Holds a processor core in reset, releases it for one program run, and reports completion.
// Optional RUN-cycle abort is enabled by defining SEQ_TIMEOUT_EN.
module core_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             core_done,
    output logic             core_reset,
    output logic             core_req,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              first_q, first_d;
    logic              done_q, done_d;
    logic              cnt_clear;
    logic              cnt_en;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        first_d    = 1'b0;
        done_d     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmr_d      = tmr_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HOLD_RST;
                    hold_cnt_d = '0;
                    cnt_clear  = 1'b1;
                end
            end
            HOLD_RST: begin
                if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    first_d = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                cnt_en = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                tmr_d  = tmr_q + TMR_W'(1);
`endif
                // core_done is tested first so it wins a tie with the limit
                if (core_done) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d   = FINISH;
                    timeout_d = 1'b1;
                end
`endif
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmr_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            first_q    <= first_d;
            done_q     <= done_d;
`ifdef SEQ_TIMEOUT_EN
            tmr_q      <= tmr_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_count)
    );

    assign core_reset = (state_q != RUN);
    assign core_req   = (state_q == RUN) && first_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
`ifdef SEQ_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule
